prescaled_counter: RTL and testbench
====================================

PRESCALED_COUNTER -- requirements
Module: prescaled_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 10, count register width in bits.
REQ-002 SHALL have parameter PRESCALE, default 1000000, clk cycles per count step (legal range 1 and up).
REQ-003 SHALL have parameter MODULUS, default 1000, number of count states (legal range 2 to 2^WIDTH).
REQ-004 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port en  input  1  enables the prescaler; the prescaler holds when en=0.
REQ-007 SHALL have port dir  input  1  step direction: 1 counts up, 0 counts down.
REQ-008 SHALL have port mode  input  2  mode select: 0 wrap, 1 saturate, 2 one-shot, 3 treated as wrap.
REQ-009 SHALL have port load  input  1  synchronous load strobe.
REQ-010 SHALL have port load_val  input  WIDTH  value written to count on load.
REQ-011 SHALL have port count  output  WIDTH  current count, registered.
REQ-012 SHALL have port tick  output  1  registered one-cycle prescaler strobe.
REQ-013 SHALL have port tc  output  1  registered one-cycle terminal-count pulse.
REQ-014 SHALL have port done  output  1  sticky one-shot completion flag.

Function
REQ-015 Prescaler SHALL be a register of max(1,$clog2(PRESCALE)) bits counting 0..PRESCALE-1 while en=1, returning to 0 after PRESCALE-1.
REQ-016 tick SHALL be 1 for exactly the cycle after the prescaler register equals PRESCALE-1 with en=1; with PRESCALE=1, tick SHALL be 1 every cycle after an en=1 cycle.
REQ-017 A step SHALL occur on a clk edge where tick=1, load=0 and done=0; count SHALL change one cycle after tick asserts.
REQ-018 Terminal value SHALL be MODULUS-1 when dir=1 and 0 when dir=0, with dir sampled on the step cycle.
REQ-019 A non-terminal step SHALL set count to count+1 (up) or count-1 (down).
REQ-020 A step at the terminal value SHALL assert tc for one cycle, in every mode.
REQ-021 In wrap mode, a step at the terminal value SHALL load 0 (up) or MODULUS-1 (down).
REQ-022 In saturate mode, a step at the terminal value SHALL hold count; tc SHALL re-pulse on every such step.
REQ-023 In one-shot mode, a step at the terminal value SHALL hold count and set done=1; while done=1 no steps occur and tc stays 0.
REQ-024 load=1 SHALL set count to load_val, or to MODULUS-1 when load_val >= MODULUS.
REQ-025 load=1 SHALL also clear the prescaler, done, tick and tc in the same edge.
REQ-026 Priority SHALL be reset > load > step; a load coincident with tick SHALL suppress that step.
REQ-027 Changes to mode or dir SHALL take effect on the next step; a change of mode SHALL NOT clear done.
REQ-028 When en=0, count SHALL hold and tick SHALL deassert on the next cycle; load SHALL still act.

Reset
REQ-029 reset=1 SHALL, on the next clk edge, set count=0, prescaler=0, tick=0, tc=0, done=0, regardless of en, tick or load.
REQ-030 reset asserted mid-prescale or mid-count SHALL discard all progress; counting resumes from prescaler 0 after release.

Verification
REQ-031 Bench (WIDTH=4, PRESCALE=4, MODULUS=10) SHALL cover: en=1, dir=1, mode=0 from reset -> tick every 4th cycle; count runs 0..9 then 0, with tc high on the 9->0 step.
REQ-032 SHALL cover: dir=0, mode=1, load count=2 -> count reaches 0 and stays 0; tc pulses on each later tick.
REQ-033 SHALL cover: mode=2, dir=1, load_val=8 -> count becomes 9; done=1 after the next step; count stays 9; only one tc pulse.
REQ-034 SHALL cover: load_val=15 -> count=9; load on a tick cycle -> no step that cycle and prescaler restarts at 0.
REQ-035 SHALL cover: reset pulsed at count=5 with prescaler=2 -> next cycle all outputs 0; first tick 4 cycles after release.
REQ-036 SHALL cover: PRESCALE=1, en toggling 1,0,1 -> count advances only on cycles following en=1.

Source files
------------

// File: rtl/prescaled_counter.sv
// Prescaled up/down counter with wrap, saturate and one-shot terminal behaviour.
// A free-running prescaler emits a tick that advances the count one cycle later.
module prescaled_counter #(
  parameter int WIDTH    = 10,
  parameter int PRESCALE = 1000000,
  parameter int MODULUS  = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tick,
  output logic             tc,
  output logic             done
);

  localparam int PW = ($clog2(PRESCALE) > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]    PMAX = PW'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] CMAX = WIDTH'(MODULUS - 1);

  typedef enum logic [1:0] {
    MODE_WRAP     = 2'd0,
    MODE_SAT      = 2'd1,
    MODE_ONESHOT  = 2'd2,
    MODE_WRAP_ALT = 2'd3
  } mode_e;

  logic [PW-1:0]    presc_q, presc_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             tick_q, tick_d;
  logic             tc_q, tc_d;
  logic             done_q, done_d;
  logic             step;
  logic             at_term;
  mode_e            mode_sel;

  assign mode_sel = mode_e'(mode);
  assign step     = tick_q && !done_q;
  assign at_term  = dir ? (count_q == CMAX) : (count_q == '0);

  always_comb begin
    presc_d = presc_q;
    count_d = count_q;
    tick_d  = 1'b0;
    tc_d    = 1'b0;
    done_d  = done_q;

    if (reset) begin
      presc_d = '0;
      count_d = '0;
      done_d  = 1'b0;
    end else if (load) begin
      // Load clamps out-of-range values and restarts the prescale period.
      presc_d = '0;
      count_d = (load_val > CMAX) ? CMAX : load_val;
      done_d  = 1'b0;
    end else begin
      if (en) begin
        tick_d  = (presc_q == PMAX);
        presc_d = (presc_q == PMAX) ? '0 : presc_q + PW'(1);
      end
      if (step) begin
        if (!at_term) begin
          count_d = dir ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
        end else begin
          tc_d = 1'b1;
          unique case (mode_sel)
            MODE_SAT:     count_d = count_q;
            MODE_ONESHOT: done_d  = 1'b1;
            default:      count_d = dir ? '0 : CMAX;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    presc_q <= presc_d;
    count_q <= count_d;
    tick_q  <= tick_d;
    tc_q    <= tc_d;
    done_q  <= done_d;
  end

  assign count = count_q;
  assign tick  = tick_q;
  assign tc    = tc_q;
  assign done  = done_q;

endmodule

// File: tb/tb_prescaled_counter.sv
// Bench for prescaled_counter: PRESCALE=4 and PRESCALE=1 instances driven in
// parallel and compared every cycle against an arithmetic reference model.
module tb_prescaled_counter;

  localparam int W   = 4;
  localparam int MOD = 10;

  logic         clk = 1'b0;
  logic         reset, en, dir, load;
  logic [1:0]   mode;
  logic [W-1:0] load_val;

  logic [W-1:0] count_a, count_b;
  logic         tick_a, tick_b, tc_a, tc_b, done_a, done_b;

  int vectors = 0;
  int errors  = 0;
  int tc_seen_a, tc_seen_b;

  int m_count[2], m_ph[2], m_tick[2], m_tc[2], m_done[2];

  always #5 clk = ~clk;

  prescaled_counter #(.WIDTH(W), .PRESCALE(4), .MODULUS(MOD)) dut_a (
    .clk(clk), .reset(reset), .en(en), .dir(dir), .mode(mode), .load(load),
    .load_val(load_val), .count(count_a), .tick(tick_a), .tc(tc_a), .done(done_a)
  );

  prescaled_counter #(.WIDTH(W), .PRESCALE(1), .MODULUS(MOD)) dut_b (
    .clk(clk), .reset(reset), .en(en), .dir(dir), .mode(mode), .load(load),
    .load_val(load_val), .count(count_b), .tick(tick_b), .tc(tc_b), .done(done_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: prescaler is a phase modulo P, wrap is modulo-MOD arithmetic.
  task automatic model_edge(input int k);
    int  p;
    bit  stp, term;
    int  nt;
    p = (k == 0) ? 4 : 1;
    if (reset) begin
      m_count[k] = 0; m_ph[k] = 0; m_tick[k] = 0; m_tc[k] = 0; m_done[k] = 0;
    end else if (load) begin
      m_count[k] = (int'(load_val) >= MOD) ? MOD - 1 : int'(load_val);
      m_ph[k] = 0; m_tick[k] = 0; m_tc[k] = 0; m_done[k] = 0;
    end else begin
      stp = (m_tick[k] != 0) && (m_done[k] == 0);
      nt  = (en && m_ph[k] == p - 1) ? 1 : 0;
      if (en) m_ph[k] = (m_ph[k] + 1) % p;
      m_tc[k] = 0;
      if (stp) begin
        term = dir ? (m_count[k] == MOD - 1) : (m_count[k] == 0);
        if (!term) begin
          m_count[k] = dir ? m_count[k] + 1 : m_count[k] - 1;
        end else begin
          m_tc[k] = 1;
          if (mode == 2'd2) m_done[k] = 1;
          else if (mode != 2'd1) m_count[k] = (m_count[k] + (dir ? 1 : MOD - 1)) % MOD;
        end
      end
      m_tick[k] = nt;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    @(negedge clk);
    if (tc_a) tc_seen_a++;
    if (tc_b) tc_seen_b++;
    check("a_count", 32'(count_a), 32'(m_count[0]));
    check("a_tick",  32'(tick_a),  32'(m_tick[0]));
    check("a_tc",    32'(tc_a),    32'(m_tc[0]));
    check("a_done",  32'(done_a),  32'(m_done[0]));
    check("b_count", 32'(count_b), 32'(m_count[1]));
    check("b_tick",  32'(tick_b),  32'(m_tick[1]));
    check("b_tc",    32'(tc_b),    32'(m_tc[1]));
    check("b_done",  32'(done_b),  32'(m_done[1]));
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; dir = 1'b1; mode = 2'd0; load = 1'b0; load_val = '0;
    for (int k = 0; k < 2; k++) begin
      m_count[k] = 0; m_ph[k] = 0; m_tick[k] = 0; m_tc[k] = 0; m_done[k] = 0;
    end
    cyc(); cyc();
    check("rst_count", 32'(count_a), 0);
    check("rst_flags", {29'd0, tick_a, tc_a, done_a}, 0);

    // Count up in wrap mode from reset through the 9 -> 0 rollover.
    reset = 1'b0; en = 1'b1; dir = 1'b1; mode = 2'd0;
    for (int i = 0; i < 46; i++) cyc();

    // Saturate down from 2: holds at 0, tc on every later tick.
    dir = 1'b0; mode = 2'd1; load = 1'b1; load_val = 4'd2;
    cyc();
    load = 1'b0;
    tc_seen_a = 0;
    for (int i = 0; i < 30; i++) cyc();
    check("sat_count", 32'(count_a), 0);
    check("sat_tc_repulse", (tc_seen_a >= 4) ? 1 : 0, 1);

    // One-shot up from 8: a single tc, then done with count parked at 9.
    mode = 2'd2; dir = 1'b1; load = 1'b1; load_val = 4'd8;
    cyc();
    load = 1'b0;
    tc_seen_a = 0; tc_seen_b = 0;
    for (int i = 0; i < 24; i++) cyc();
    check("os_count_a", 32'(count_a), 9);
    check("os_done_a",  32'(done_a), 1);
    check("os_tc_a",    tc_seen_a, 1);
    check("os_count_b", 32'(count_b), 9);
    check("os_tc_b",    tc_seen_b, 1);
    mode = 2'd0;
    cyc();
    check("os_done_kept", 32'(done_a), 1);

    // Out-of-range load clamps; load on a tick cycle suppresses the step.
    load = 1'b1; load_val = 4'd15;
    cyc();
    check("clamp_a", 32'(count_a), 9);
    check("clamp_b", 32'(count_b), 9);
    load = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      if (m_tick[0] != 0) break;
    end
    check("tick_before_load", 32'(tick_a), 1);
    load = 1'b1; load_val = 4'd3;
    cyc();
    load = 1'b0;
    check("load_on_tick", 32'(count_a), 3);
    for (int i = 0; i < 6; i++) cyc();

    // Reset mid-prescale at count 5, prescaler 2.
    load = 1'b1; load_val = 4'd5;
    cyc();
    load = 1'b0;
    cyc(); cyc();
    check("pre_reset_count", 32'(count_a), 5);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check("mid_rst_count", 32'(count_a), 0);
    check("mid_rst_flags", {29'd0, tick_a, tc_a, done_a}, 0);
    cyc(); cyc(); cyc();
    check("no_early_tick", 32'(tick_a), 0);
    cyc();
    check("first_tick", 32'(tick_a), 1);

    // en toggling, mainly exercising the PRESCALE=1 instance.
    for (int i = 0; i < 12; i++) begin
      en = (i % 3 != 1);
      cyc();
    end
    en = 1'b1;

    // Randomised traffic with occasional loads and resets.
    for (int i = 0; i < 500; i++) begin
      en       = ($urandom_range(0, 3) != 0);
      dir      = 1'($urandom_range(0, 1));
      mode     = 2'($urandom_range(0, 3));
      load     = ($urandom_range(0, 19) == 0);
      load_val = 4'($urandom_range(0, 15));
      reset    = ($urandom_range(0, 63) == 0);
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
